// File: rtl/ro_puf_cell.sv
// ro_puf_cell: ring-oscillator PUF cell; counts rising edges of two challenged rings
// over a fixed clk window and compares them into one response bit.
module ro_puf_cell #(
    parameter int NUM_RO        = 16,
    parameter int NUM_STAGES    = 7,
    parameter int SEL_WIDTH     = 4,
    parameter int CNT_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int WINDOW_CYCLES = 1024,
    parameter bit EXT_OSC       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SEL_WIDTH-1:0] challenge_a,
    input  logic [SEL_WIDTH-1:0] challenge_b,
    input  logic [NUM_RO-1:0]    test_osc,
    output logic                 busy,
    output logic                 done,
    output logic                 response,
    output logic                 tie,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] count_a,
    output logic [CNT_WIDTH-1:0] count_b,
    output logic [NUM_RO-1:0]    ro_enable
);
    localparam int TMAX = SETTLE_CYCLES > WINDOW_CYCLES ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, COUNT, DRAIN, COMPARE, DONE, ERR} state_t;

    state_t                state;
    logic [TW-1:0]         timer;
    logic [SEL_WIDTH-1:0]  sel_a, sel_b;
    logic [2:0]            sync_a, sync_b;
    logic [CNT_WIDTH-1:0]  cnt_a, cnt_b;
    logic [NUM_RO-1:0]     osc;
    logic [2**SEL_WIDTH-1:0] osc_pad;
    logic                  cnt_en, edge_a, edge_b, illegal;

    if (EXT_OSC) begin : g_ext
        assign osc = test_osc & ro_enable;
    end else begin : g_ring
        logic ext_unused;
        assign ext_unused = ^test_osc;
        // disabled rings sit static: NAND output high, inverter chain frozen
        for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
            (* keep = "true" *) logic [NUM_STAGES-1:0] st;
            assign st[0] = ~(ro_enable[i] & st[NUM_STAGES-1]);
            for (genvar j = 1; j < NUM_STAGES; j++) begin : g_inv
                assign st[j] = ~st[j-1];
            end
            assign osc[i] = st[NUM_STAGES-1];
        end
    end

    assign osc_pad = (2**SEL_WIDTH)'(osc);
    assign cnt_en  = state == COUNT || state == DRAIN;
    assign edge_a  = sync_a[1] & ~sync_a[2];
    assign edge_b  = sync_b[1] & ~sync_b[2];
    assign illegal = challenge_a == challenge_b || int'(challenge_a) >= NUM_RO
                     || int'(challenge_b) >= NUM_RO;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            sel_a     <= '0;
            sel_b     <= '0;
            sync_a    <= '0;
            sync_b    <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            ro_enable <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            response  <= 1'b0;
            tie       <= 1'b0;
            error     <= 1'b0;
            count_a   <= '0;
            count_b   <= '0;
        end else begin
            sync_a <= {sync_a[1:0], osc_pad[sel_a]};
            sync_b <= {sync_b[1:0], osc_pad[sel_b]};
            done   <= 1'b0;
            if (cnt_en && edge_a && cnt_a != '1) cnt_a <= cnt_a + 1'b1;
            if (cnt_en && edge_b && cnt_b != '1) cnt_b <= cnt_b + 1'b1;
            case (state)
                IDLE: if (start) begin
                    sel_a    <= challenge_a;
                    sel_b    <= challenge_b;
                    response <= 1'b0;
                    tie      <= 1'b0;
                    error    <= 1'b0;
                    count_a  <= '0;
                    count_b  <= '0;
                    if (illegal) state <= ERR;
                    else begin
                        cnt_a     <= '0;
                        cnt_b     <= '0;
                        ro_enable <= (NUM_RO'(1) << challenge_a) | (NUM_RO'(1) << challenge_b);
                        busy      <= 1'b1;
                        timer     <= TW'(SETTLE_CYCLES - 1);
                        state     <= SETTLE;
                    end
                end
                SETTLE: if (timer == '0) begin
                    timer <= TW'(WINDOW_CYCLES - 1);
                    state <= COUNT;
                end else timer <= timer - 1'b1;
                COUNT: if (timer == '0) begin
                    ro_enable <= '0;
                    timer     <= TW'(1);
                    state     <= DRAIN;
                end else timer <= timer - 1'b1;
                DRAIN: if (timer == '0) state <= COMPARE;
                       else timer <= timer - 1'b1;
                COMPARE: begin
                    response <= cnt_a > cnt_b;
                    tie      <= cnt_a == cnt_b;
                    count_a  <= cnt_a;
                    count_b  <= cnt_b;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                ERR: begin
                    error <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ro_puf_cell.sv
// tb_ro_puf_cell: drives square waves on test_osc and checks counts, flags and timing
// against edge counts derived from oscillator period and window length.
module tb_ro_puf_cell;
    // one time unit is 0.5 ns; clk is 100 MHz
    logic        clk, rst, start;
    logic [4:0]  challenge_a, challenge_b;
    logic [15:0] test_osc;
    logic        busy, done, response, tie, error;
    logic [15:0] count_a, count_b, ro_enable;
    logic        busy2, done2, response2, tie2, error2;
    logic [5:0]  count_a2, count_b2;
    logic [15:0] ro_enable2;

    ro_puf_cell #(.NUM_RO(16), .NUM_STAGES(7), .SEL_WIDTH(5), .CNT_WIDTH(16),
                  .SETTLE_CYCLES(8), .WINDOW_CYCLES(1024), .EXT_OSC(1)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge_a(challenge_a),
        .challenge_b(challenge_b), .test_osc(test_osc), .busy(busy), .done(done),
        .response(response), .tie(tie), .error(error), .count_a(count_a),
        .count_b(count_b), .ro_enable(ro_enable));

    ro_puf_cell #(.NUM_RO(16), .NUM_STAGES(7), .SEL_WIDTH(5), .CNT_WIDTH(6),
                  .SETTLE_CYCLES(8), .WINDOW_CYCLES(1024), .EXT_OSC(1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .challenge_a(challenge_a),
        .challenge_b(challenge_b), .test_osc(test_osc), .busy(busy2), .done(done2),
        .response(response2), .tie(tie2), .error(error2), .count_a(count_a2),
        .count_b(count_b2), .ro_enable(ro_enable2));

    typedef struct {
        int   a, b, pa, pb, ea, eb;
        logic resp, tie;
    } vec_t;

    int          total = 0, bad = 0;
    int          per [16];
    int          ph [16];
    int          tn = 0;
    int          lat, ndone;
    logic        leak, busy1, busy_d;
    logic [15:0] en1;

    initial begin
        clk = 0;
        forever #10 clk = ~clk;
    end

    // square waves evaluated every ns, offset half a ns from clk edges
    initial begin
        for (int k = 0; k < 16; k++) begin per[k] = 0; ph[k] = 0; end
        test_osc = '0;
        #1;
        forever begin
            for (int k = 0; k < 16; k++)
                test_osc[k] = per[k] > 0 && ((tn + ph[k]) % per[k]) < per[k] / 2;
            #2;
            tn++;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input longint act, input longint exp, input longint tol);
        total++;
        if (act < exp - tol || act > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d+-%0d", nm, act, exp, tol);
        end
    endtask

    task automatic measure(input int a, input int b, input int ra, input int rb,
                           input int restart_at, input logic [15:0] mask);
        lat = -1; ndone = 0; leak = 0; busy1 = 0; busy_d = 1; en1 = '0;
        @(negedge clk);
        challenge_a = 5'(a); challenge_b = 5'(b); start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 1) begin busy1 = busy; en1 = ro_enable; end
            if (|(ro_enable & ~mask)) leak = 1;
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = k; busy_d = busy; end
            end
            if (k == restart_at) begin
                challenge_a = 5'(ra); challenge_b = 5'(rb); start = 1;
            end
        end
    endtask

    task automatic run_row(input vec_t v, input int tol, input bit rph,
                           input int restart_at, input string tag);
        logic [15:0] m;
        for (int k = 0; k < 16; k++) begin
            per[k] = 50;
            ph[k] = rph ? int'($urandom_range(0, 199)) : 0;
        end
        per[v.a] = v.pa;
        per[v.b] = v.pb;
        m = (16'(1) << v.a) | (16'(1) << v.b);
        measure(v.a, v.b, 2, 9, restart_at, m);
        chk({tag, " latency"}, lat, 1036);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " busy"}, busy1, 1);
        chk({tag, " busy at done"}, busy_d, 0);
        chk({tag, " enables"}, en1, m);
        chk({tag, " enable leak"}, leak, 0);
        chk_tol({tag, " count_a"}, count_a, v.ea, tol);
        chk_tol({tag, " count_b"}, count_b, v.eb, tol);
        chk({tag, " response"}, response, v.resp);
        chk({tag, " tie"}, tie, v.tie);
        chk({tag, " error"}, error, 0);
        if (v.ea >= 65 && v.eb >= 65) begin
            chk({tag, " sat count_a"}, count_a2, 63);
            chk({tag, " sat count_b"}, count_b2, 63);
            chk({tag, " sat tie"}, tie2, 1);
            chk({tag, " sat response"}, response2, 0);
        end
    endtask

    task automatic run_err(input int a, input int b, input string tag);
        measure(a, b, 0, 0, 0, 16'h0);
        chk({tag, " latency"}, lat, 2);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " error"}, error, 1);
        chk({tag, " count_a"}, count_a, 0);
        chk({tag, " count_b"}, count_b, 0);
        chk({tag, " response"}, response, 0);
        chk({tag, " tie"}, tie, 0);
        chk({tag, " enable leak"}, leak, 0);
    endtask

    initial begin
        vec_t tv [4];
        tv[0] = '{3, 5, 80, 120, 128, 85, 1'b1, 1'b0};
        tv[1] = '{5, 3, 80, 120, 128, 85, 1'b0, 1'b0};
        tv[2] = '{3, 5, 100, 100, 102, 102, 1'b0, 1'b1};
        tv[3] = '{3, 5, 40, 40, 256, 256, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tv[i].a = (i == 1) ? 5 : 3;
            tv[i].b = (i == 1) ? 3 : 5;
        end
        tv[1].pa = 120; tv[1].pb = 80; tv[1].ea = 85; tv[1].eb = 128;

        rst = 1; start = 0; challenge_a = '0; challenge_b = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset enables", ro_enable, 0);
        chk("reset counts", {count_a, count_b}, 0);
        chk("reset flags", {response, tie, error}, 0);
        rst = 0;

        for (int i = 0; i < 4; i++) run_row(tv[i], 1, 0, 0, $sformatf("vec%0d", i));

        run_err(7, 7, "err same");
        run_err(20, 3, "err a range");
        run_err(2, 16, "err b range");

        for (int r = 0; r < 6; r++) begin
            vec_t v;
            int a, b, pa, pb;
            a = int'($urandom_range(0, 15));
            do b = int'($urandom_range(0, 15)); while (b == a);
            do begin
                pa = 2 * int'($urandom_range(20, 100));
                pb = 2 * int'($urandom_range(20, 100));
            end while ((10240 / pa - 10240 / pb) inside {[-4:4]});
            v = '{a, b, pa, pb, 10240 / pa, 10240 / pb, pa < pb, 1'b0};
            run_row(v, 2, 1, 0, $sformatf("rand%0d a=%0d b=%0d pa=%0d pb=%0d", r, a, b, pa, pb));
        end

        run_row(tv[0], 1, 0, 100, "restart ignored");

        for (int k = 0; k < 16; k++) begin per[k] = 50; ph[k] = 0; end
        per[3] = 80; per[5] = 120;
        @(negedge clk);
        challenge_a = 3; challenge_b = 5; start = 1;
        @(negedge clk);
        start = 0;
        repeat (508) @(negedge clk);
        chk("pre-abort busy", busy, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort busy", busy, 0);
        chk("abort enables", ro_enable, 0);
        chk("abort done", done, 0);
        chk("abort counts", {count_a, count_b}, 0);
        chk("abort flags", {response, tie, error}, 0);
        @(negedge clk);
        run_row(tv[0], 1, 0, 0, "after abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ro_puf_cell.md
Name: ro_puf_cell

Overview:
- Parametrised ring-oscillator PUF measurement cell: an array of NUM_RO gated ring oscillators, each NUM_STAGES long (one NAND enable stage plus inverters).
- A challenge selects two oscillators. Their rising edges are counted in the clk domain over a fixed window, and the counts are compared to produce one response bit.
- Sits under the PUF controller, which issues challenges and collects response bits.

Parameters:
- NUM_RO, 16, number of ring oscillators in the array (2..256).
- NUM_STAGES, 7, ring length including the NAND stage; must be odd, at least 3.
- SEL_WIDTH, 4, width of each challenge index; NUM_RO must not exceed 2**SEL_WIDTH.
- CNT_WIDTH, 16, edge counter width; counters saturate.
- SETTLE_CYCLES, 8, clk cycles between ring enable and start of counting.
- WINDOW_CYCLES, 1024, clk cycles of counting.
- EXT_OSC, 0, oscillator source: 0 = internal keep-attributed rings, 1 = test_osc bus replaces rings (simulation/bring-up).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle measurement request, sampled only in IDLE
- challenge_a  in  SEL_WIDTH  index of oscillator A
- challenge_b  in  SEL_WIDTH  index of oscillator B
- test_osc  in  NUM_RO  external oscillator inputs, used only when EXT_OSC=1
- busy  out  1  measurement in progress
- done  out  1  one-cycle pulse, results valid
- response  out  1  1 when count_a > count_b
- tie  out  1  count_a == count_b
- error  out  1  illegal challenge
- count_a  out  CNT_WIDTH  edges counted on A
- count_b  out  CNT_WIDTH  edges counted on B
- ro_enable  out  NUM_RO  per-ring enable, exported for debug

Behaviour:
- Reset (synchronous, rst high at a clk edge): state IDLE; all outputs 0; counters and synchronisers cleared; all ring enables 0. Reset mid-measurement aborts immediately with no done pulse.
- Only the two selected rings are ever enabled. All others are held with the NAND input low (static, no toggling).
- Challenge indices are latched on the accepted start and held for the whole measurement.
- Oscillator path, per side: selected oscillator output -> mux -> 2-flop synchroniser -> rising-edge detect (sync2 & ~sync3) -> saturating counter. A counter at 2**CNT_WIDTH-1 stays there.
- Measurable frequency is below f_clk/2; faster rings alias, and this is not detected.
- FSM states:
  - IDLE: busy=0. On start: error check (next bullet); if legal, latch indices, clear counters, assert both enables, go to SETTLE.
  - Error check: challenge_a == challenge_b, or either index >= NUM_RO, goes to ERR.
  - SETTLE: SETTLE_CYCLES cycles with counting disabled, so edges are discarded.
  - COUNT: WINDOW_CYCLES cycles with counting enabled.
  - DRAIN: 2 cycles. Enables drop on entry; edge detection continues so that edges already in the synchronisers are counted.
  - COMPARE: 1 cycle. Register response, tie, count_a, count_b.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
  - ERR: error=1, done=1 for one cycle; counts, response and tie are 0; then IDLE.
- busy is 1 from the cycle after an accepted start through COMPARE.
- Latency: done is asserted SETTLE_CYCLES+WINDOW_CYCLES+4 cycles after the edge that samples start (illegal challenge: 2 cycles).
- response, tie, error and the counts hold their values until the next accepted start. They clear on that start.
- start while busy is ignored, with no queuing. start and rst together: rst wins.
- Tie: response=0, tie=1.
- EXT_OSC=1: rings are not instantiated; ro_enable still follows the FSM; test_osc bits are gated by ro_enable before the mux.

Test Plan:
- EXT_OSC=1, clk 100 MHz, test_osc[3] period 80 ns, test_osc[5] period 120 ns, a=3, b=5, WINDOW=1024 -> done at cycle start+1036; count_a 128±1; count_b 85±1; response=1; tie=0; only ro_enable[3] and ro_enable[5] high during SETTLE/COUNT.
- Same stimulus with a=5, b=3 -> response=0; counts swapped.
- Both oscillators at 100 ns, in phase -> count_a == count_b == 102±1; tie=1; response=0.
- a=b=7, or a=20 with NUM_RO=16 -> done 2 cycles after start; error=1; counts 0; ro_enable never asserted.
- CNT_WIDTH=6, test_osc at 40 ns -> both counts saturate at 63; tie=1.
- rst pulsed at COUNT cycle 500 -> next cycle busy=0, ro_enable=0, all outputs 0, no done. A start given 2 cycles later then completes normally.
- A second start issued mid-measurement -> ignored; exactly one done pulse.
